// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types, defaults and the saturating-counter step used by the
// tournament branch predictor and its counter tables.
package tournament_branch_predictor_pkg;

    localparam int history_depth          = 8;
    localparam int bht_s_index            = 8;
    localparam int tournament_pht_s_index = 8;
    localparam int perf_counter_width     = 32;

    localparam logic [1:0] BP_CTR_INIT  = 2'b01;
    localparam logic [1:0] CHOOSER_INIT = 2'b01;

    // Everything execute hands back for one resolved conditional branch.
    typedef struct packed {
        logic                     valid;
        logic [31:0]              pc;
        logic                     taken;
        logic [history_depth-1:0] local_idx;
        logic [history_depth-1:0] global_idx;
        logic [history_depth-1:0] ghr_snapshot;
        logic                     local_pr;
        logic                     global_pr;
        logic                     br_pr;
    } bp_update_t;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!up && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tournament_branch_predictor_sat_ctr_table.sv
// Table of 2-bit saturating counters: asynchronous read, one saturating
// update per clock, asynchronous reset to a configurable initial value.
module bp_sat_ctr_table
    import tournament_branch_predictor_pkg::*;
#(
    parameter int         IDX  = 8,
    parameter logic [1:0] INIT = BP_CTR_INIT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic [1:0]     rd_ctr,
    input  logic           upd_en,
    input  logic [IDX-1:0] upd_idx,
    input  logic           upd_up
);

    localparam int N = 1 << IDX;

    logic [1:0] ctr_q [N];
    logic [1:0] ctr_d [N];

    // Reads see the registered value, so a same-cycle update is not visible yet.
    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = sat_step(ctr_q[upd_idx], upd_up);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= INIT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament (local/global, optional gshare) direction predictor with
// speculative global history, mispredict repair and saturating perf counters.
module tournament_branch_predictor
    import tournament_branch_predictor_pkg::*;
#(
    parameter int HIST_DEPTH      = history_depth,
    parameter int BHT_S_INDEX     = bht_s_index,
    parameter int CHOOSER_S_INDEX = tournament_pht_s_index,
    parameter int GSHARE          = 1,
    parameter int PERF_W          = perf_counter_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic                  pred_is_br,
    input  logic [31:0]           pred_pc,
    output logic [HIST_DEPTH-1:0] local_pht_index,
    output logic [HIST_DEPTH-1:0] global_pht_index,
    output logic [HIST_DEPTH-1:0] ghr_snapshot,
    output logic                  local_pr,
    output logic                  global_pr,
    output logic                  br_pr,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    input  logic [HIST_DEPTH-1:0] upd_local_idx,
    input  logic [HIST_DEPTH-1:0] upd_global_idx,
    input  logic [HIST_DEPTH-1:0] upd_ghr_snapshot,
    input  logic                  upd_local_pr,
    input  logic                  upd_global_pr,
    input  logic                  upd_br_pr,
    output logic [PERF_W-1:0]     perf_lookups,
    output logic [PERF_W-1:0]     perf_mispredicts
);

    localparam int BHT_N = 1 << BHT_S_INDEX;

    logic [HIST_DEPTH-1:0]      bht_q [BHT_N];
    logic [HIST_DEPTH-1:0]      bht_d [BHT_N];
    logic [HIST_DEPTH-1:0]      ghr_q, ghr_d;
    logic [PERF_W-1:0]          perf_lookups_q, perf_lookups_d;
    logic [PERF_W-1:0]          perf_mispredicts_q, perf_mispredicts_d;
    logic [1:0]                 local_ctr, global_ctr, chooser_ctr;
    logic                       mispredict;
    logic [BHT_S_INDEX-1:0]     pred_bht_idx, upd_bht_idx;
    logic [CHOOSER_S_INDEX-1:0] pred_ch_idx, upd_ch_idx;

    assign pred_bht_idx = pred_pc[BHT_S_INDEX+1:2];
    assign upd_bht_idx  = upd_pc[BHT_S_INDEX+1:2];
    assign pred_ch_idx  = pred_pc[CHOOSER_S_INDEX+1:2];
    assign upd_ch_idx   = upd_pc[CHOOSER_S_INDEX+1:2];

    assign local_pht_index = bht_q[pred_bht_idx];
    generate
        if (GSHARE != 0) begin : g_gshare
            assign global_pht_index = ghr_q ^ pred_pc[HIST_DEPTH+1:2];
        end else begin : g_global
            assign global_pht_index = ghr_q;
        end
    endgenerate

    assign ghr_snapshot     = ghr_q;
    assign local_pr         = local_ctr[1];
    assign global_pr        = global_ctr[1];
    assign br_pr            = chooser_ctr[1] ? global_pr : local_pr;
    assign mispredict       = upd_valid && (upd_br_pr != upd_taken);
    assign perf_lookups     = perf_lookups_q;
    assign perf_mispredicts = perf_mispredicts_q;

    bp_sat_ctr_table #(.IDX(HIST_DEPTH), .INIT(BP_CTR_INIT)) u_local_pht (
        .clk     (clk),
        .rst_n   (rst),
        .rd_idx  (local_pht_index),
        .rd_ctr  (local_ctr),
        .upd_en  (upd_valid),
        .upd_idx (upd_local_idx),
        .upd_up  (upd_taken)
    );

    bp_sat_ctr_table #(.IDX(HIST_DEPTH), .INIT(BP_CTR_INIT)) u_global_pht (
        .clk     (clk),
        .rst_n   (rst),
        .rd_idx  (global_pht_index),
        .rd_ctr  (global_ctr),
        .upd_en  (upd_valid),
        .upd_idx (upd_global_idx),
        .upd_up  (upd_taken)
    );

    // Chooser only learns when the two components disagreed; up means "trust global".
    bp_sat_ctr_table #(.IDX(CHOOSER_S_INDEX), .INIT(CHOOSER_INIT)) u_chooser (
        .clk     (clk),
        .rst_n   (rst),
        .rd_idx  (pred_ch_idx),
        .rd_ctr  (chooser_ctr),
        .upd_en  (upd_valid && (upd_local_pr != upd_global_pr)),
        .upd_idx (upd_ch_idx),
        .upd_up  (upd_global_pr == upd_taken)
    );

    // A resolved mispredict rebuilds history from its snapshot, overriding any speculative shift.
    always_comb begin
        ghr_d              = ghr_q;
        bht_d              = bht_q;
        perf_lookups_d     = perf_lookups_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (pred_valid && pred_is_br) begin
            ghr_d = {ghr_q[HIST_DEPTH-2:0], br_pr};
        end
        if (mispredict) begin
            ghr_d = {upd_ghr_snapshot[HIST_DEPTH-2:0], upd_taken};
        end
        if (upd_valid) begin
            bht_d[upd_bht_idx] = {bht_q[upd_bht_idx][HIST_DEPTH-2:0], upd_taken};
            if (!(&perf_lookups_q)) begin
                perf_lookups_d = perf_lookups_q + PERF_W'(1);
            end
        end
        if (mispredict && !(&perf_mispredicts_q)) begin
            perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= '0;
            end
            ghr_q              <= '0;
            perf_lookups_q     <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            bht_q              <= bht_d;
            ghr_q              <= ghr_d;
            perf_lookups_q     <= perf_lookups_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Scoreboard bench: stimulus pushes reference-model predictions, a negedge
// monitor pops and compares them against the DUT's combinational outputs.
module tb_tournament_branch_predictor;
    import tournament_branch_predictor_pkg::*;

    localparam int H    = 8;
    localparam int PW   = 4;
    localparam int N    = 256;
    localparam int PMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid, pred_is_br;
    logic [31:0]   pred_pc;
    logic [H-1:0]  local_pht_index, global_pht_index, ghr_snapshot;
    logic          local_pr, global_pr, br_pr;
    logic          upd_valid, upd_taken, upd_local_pr, upd_global_pr, upd_br_pr;
    logic [31:0]   upd_pc;
    logic [H-1:0]  upd_local_idx, upd_global_idx, upd_ghr_snapshot;
    logic [PW-1:0] perf_lookups, perf_mispredicts;

    always #5 clk = ~clk;

    tournament_branch_predictor #(
        .HIST_DEPTH(H), .BHT_S_INDEX(8), .CHOOSER_S_INDEX(8), .GSHARE(1), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_is_br(pred_is_br), .pred_pc(pred_pc),
        .local_pht_index(local_pht_index), .global_pht_index(global_pht_index),
        .ghr_snapshot(ghr_snapshot), .local_pr(local_pr), .global_pr(global_pr), .br_pr(br_pr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_local_idx(upd_local_idx), .upd_global_idx(upd_global_idx),
        .upd_ghr_snapshot(upd_ghr_snapshot), .upd_local_pr(upd_local_pr),
        .upd_global_pr(upd_global_pr), .upd_br_pr(upd_br_pr),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    typedef struct {
        int lidx, gidx, snap, lpr, gpr, bpr, plk, pmis;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_exp;
    bp_update_t inflight[$];

    int m_lpht[N], m_gpht[N], m_ch[N], m_bht[N];
    int m_ghr, m_lk, m_mis;
    int checks = 0;
    int failures = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int toward(input int c, input int up);
        return up != 0 ? (c < 3 ? c + 1 : 3) : (c > 0 ? c - 1 : 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_lpht[i] = 1;
            m_gpht[i] = 1;
            m_ch[i]   = 1;
            m_bht[i]  = 0;
        end
        m_ghr = 0;
        m_lk  = 0;
        m_mis = 0;
    endfunction

    function automatic exp_t model_predict(input logic [31:0] pc);
        exp_t e;
        int   slot;
        slot   = int'(pc[9:2]);
        e.lidx = m_bht[slot];
        e.gidx = m_ghr ^ slot;
        e.snap = m_ghr;
        e.lpr  = m_lpht[e.lidx] >= 2 ? 1 : 0;
        e.gpr  = m_gpht[e.gidx] >= 2 ? 1 : 0;
        e.bpr  = m_ch[slot] >= 2 ? e.gpr : e.lpr;
        e.plk  = m_lk;
        e.pmis = m_mis;
        return e;
    endfunction

    // Apply what the DUT should have absorbed at the edge just passed.
    task automatic model_update();
        int slot, mis;
        mis = (upd_valid && (upd_br_pr != upd_taken)) ? 1 : 0;
        if (pred_valid && pred_is_br) m_ghr = ((m_ghr << 1) | last_exp.bpr) % N;
        if (mis != 0) m_ghr = ((int'(upd_ghr_snapshot) << 1) | int'(upd_taken)) % N;
        if (upd_valid) begin
            slot = int'(upd_pc[9:2]);
            m_lpht[upd_local_idx]  = toward(m_lpht[upd_local_idx], int'(upd_taken));
            m_gpht[upd_global_idx] = toward(m_gpht[upd_global_idx], int'(upd_taken));
            m_bht[slot] = ((m_bht[slot] << 1) | int'(upd_taken)) % N;
            if (upd_local_pr != upd_global_pr)
                m_ch[slot] = toward(m_ch[slot], (upd_global_pr == upd_taken) ? 1 : 0);
            if (m_lk < PMAX) m_lk++;
            if (mis != 0 && m_mis < PMAX) m_mis++;
        end
    endtask

    task automatic drive_lookup(input logic v, input logic br, input logic [31:0] pc);
        pred_valid = v;
        pred_is_br = br;
        pred_pc    = pc;
    endtask

    task automatic drive_update(input logic v, input logic [31:0] pc, input logic t,
                                input int li, input int gi, input int sn,
                                input logic lp, input logic gp, input logic bp);
        upd_valid        = v;
        upd_pc           = pc;
        upd_taken        = t;
        upd_local_idx    = H'(li);
        upd_global_idx   = H'(gi);
        upd_ghr_snapshot = H'(sn);
        upd_local_pr     = lp;
        upd_global_pr    = gp;
        upd_br_pr        = bp;
    endtask

    // One cycle: expectation queued now, model advanced after the edge.
    task automatic apply_stimulus();
        bp_update_t rec;
        last_exp = model_predict(pred_pc);
        sb.push_back(last_exp);
        if (pred_valid && pred_is_br) begin
            rec.valid        = 1'b1;
            rec.pc           = pred_pc;
            rec.taken        = 1'b0;
            rec.local_idx    = H'(last_exp.lidx);
            rec.global_idx   = H'(last_exp.gidx);
            rec.ghr_snapshot = H'(last_exp.snap);
            rec.local_pr     = last_exp.lpr[0];
            rec.global_pr    = last_exp.gpr[0];
            rec.br_pr        = last_exp.bpr[0];
            inflight.push_back(rec);
        end
        @(posedge clk);
        #1;
        if (rst) model_update();
    endtask

    // Async reset asserted mid-cycle with an update pending; checked before the next edge.
    task automatic mid_reset();
        drive_update(1'b1, 32'h40, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b1);
        #3;
        rst = 1'b0;
        model_reset();
        inflight.delete();
        sb.push_back(model_predict(pred_pc));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_output("local_pht_index", int'(local_pht_index), e.lidx);
            check_output("global_pht_index", int'(global_pht_index), e.gidx);
            check_output("ghr_snapshot", int'(ghr_snapshot), e.snap);
            check_output("local_pr", int'(local_pr), e.lpr);
            check_output("global_pr", int'(global_pr), e.gpr);
            check_output("br_pr", int'(br_pr), e.bpr);
            check_output("perf_lookups", int'(perf_lookups), e.plk);
            check_output("perf_mispredicts", int'(perf_mispredicts), e.pmis);
        end
    end

    initial begin
        bp_update_t rec;
        int guard;
        rst = 1'b0;
        drive_lookup(1'b0, 1'b0, 32'h40);
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        apply_stimulus();

        // Counter walk on index 0: taken x3 saturates, then not-taken steps back.
        for (int k = 0; k < 4; k++) begin
            drive_lookup(1'b1, 1'b0, 32'h44);
            drive_update(1'b1, 32'h40, k < 3, 0, 0, 0, k < 3, k < 3, k < 3);
            apply_stimulus();
        end
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        // Chooser learns global was right on 0x80, then lookup there follows global.
        drive_lookup(1'b1, 1'b0, 32'h80);
        drive_update(1'b1, 32'h80, 1'b1, 3, 3, 0, 1'b0, 1'b1, 1'b0);
        apply_stimulus();
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        // GHR to 0x0F, then speculative shift and repair in the same cycle.
        drive_lookup(1'b0, 1'b0, 32'h40);
        drive_update(1'b1, 32'h100, 1'b1, 9, 9, 8'h07, 1'b0, 1'b0, 1'b0);
        apply_stimulus();
        drive_lookup(1'b1, 1'b1, 32'h40);
        drive_update(1'b1, 32'h104, 1'b0, 10, 10, 8'h0F, 1'b1, 1'b1, 1'b1);
        apply_stimulus();
        drive_lookup(1'b0, 1'b0, 32'h40);
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();
        inflight.delete();

        // Update and lookup the same local counter in one cycle.
        drive_lookup(1'b1, 1'b0, 32'h44);
        drive_update(1'b1, 32'h200, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();

        // Twenty mispredicts drive both perf counters to saturation.
        for (int k = 0; k < 20; k++) begin
            drive_lookup(1'b1, 1'b0, 32'h300 + 32'(k * 4));
            drive_update(1'b1, 32'h300, 1'b0, int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         1'b1, 1'b0, 1'b1);
            apply_stimulus();
        end
        drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus();
        mid_reset();
        apply_stimulus();

        // Randomised traffic over a hot PC region with carried update records.
        for (int c = 0; c < 3000; c++) begin
            drive_lookup(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         32'h1000 + 32'($urandom_range(0, 31) * 4));
            if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                rec = inflight.pop_front();
                drive_update(1'b1, rec.pc,
                             ($urandom_range(0, 3) != 0) ? rec.pc[2] : 1'($urandom_range(0, 1)),
                             int'(rec.local_idx), int'(rec.global_idx), int'(rec.ghr_snapshot),
                             rec.local_pr, rec.global_pr, rec.br_pr);
            end else begin
                drive_update(1'b0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            end
            if ($urandom_range(0, 499) == 0) mid_reset();
            else apply_stimulus();
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
